// File: rtl/picture_writer.sv
// picture_writer: loads a WIDTH-wide picture region from a byte-serial RGB
// stream, one 24-bit pixel write per three accepted bytes, row-major.
//
// Ports
//   picture_clk, resetn      : clock, async active-low reset
//   start, abort             : begin a frame (IDLE only) / abandon a frame
//   in_byte, in_valid        : colour byte stream, order R, G, B
//   in_ready                 : byte accepted when in_valid && in_ready
//   picture_wadrs/wdata/we   : picture memory write port
//   cur_row, cur_col         : position of the pixel being assembled
//   busy, frame_done         : not idle / pulse after the last write
//   frame_count              : completed frames, wraps at 256
module picture_writer #(
    parameter int unsigned BASE_ADRS = 1792,
    parameter int unsigned PIXELS    = 256,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ADRS_W    = 11
) (
    input  logic              picture_clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADRS_W-1:0] picture_wadrs,
    output logic [23:0]       picture_wdata,
    output logic              picture_we,
    output logic [3:0]        cur_row,
    output logic [3:0]        cur_col,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_count
);

    localparam int unsigned PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADRS_W-1:0] BASE     = ADRS_W'(BASE_ADRS);
    localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(PIXELS - 1);
    localparam logic [3:0]        LAST_COL = 4'(WIDTH - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [PIX_W-1:0]  pix_idx_q, pix_idx_d;
    logic [15:0]       rg_q, rg_d;
    logic [3:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic [ADRS_W-1:0] wadrs_q, wadrs_d;
    logic [23:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        fcnt_q, fcnt_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pix_idx_d  = pix_idx_q;
        rg_d       = rg_q;
        row_d      = row_q;
        col_d      = col_q;
        wadrs_d    = wadrs_q;
        wdata_d    = wdata_q;
        fcnt_d     = fcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    byte_cnt_d = 2'd0;
                    pix_idx_d  = '0;
                    row_d      = 4'd0;
                    col_d      = 4'd0;
                    state_d    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    case (byte_cnt_q)
                        2'd0: begin
                            rg_d[15:8] = in_byte;
                            byte_cnt_d = 2'd1;
                        end
                        2'd1: begin
                            rg_d[7:0]  = in_byte;
                            byte_cnt_d = 2'd2;
                        end
                        default: begin
                            // Blue completes the pixel: latch the write port
                            // so it is presented from the WRITE cycle.
                            byte_cnt_d = 2'd0;
                            wadrs_d    = BASE + ADRS_W'(pix_idx_q);
                            wdata_d    = {rg_q, in_byte};
                            state_d    = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pix_idx_q == LAST_PIX) begin
                    fcnt_d  = fcnt_q + 8'd1;
                    state_d = S_DONE;
                end else begin
                    pix_idx_d = pix_idx_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = 4'd0;
                        row_d = row_q + 4'd1;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                    state_d = S_COLLECT;
                end
            end
            default: begin
                // DONE lasts one cycle; start is deliberately not looked at.
                state_d = S_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they are flops.
        we_d   = (state_d == S_WRITE);
        rdy_d  = (state_d == S_COLLECT);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge picture_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            pix_idx_q  <= '0;
            rg_q       <= 16'd0;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            wadrs_q    <= BASE;
            wdata_q    <= 24'd0;
            we_q       <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fcnt_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pix_idx_q  <= pix_idx_d;
            rg_q       <= rg_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wadrs_q    <= wadrs_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign in_ready      = rdy_q;
    assign picture_wadrs = wadrs_q;
    assign picture_wdata = wdata_q;
    assign picture_we    = we_q;
    assign cur_row       = row_q;
    assign cur_col       = col_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_picture_writer.sv
// tb_picture_writer: randomized scenario bench for picture_writer with a
// frame-level reference image and a small second instance for wrap-around.
module tb_picture_writer;

    logic        picture_clk = 1'b0;
    logic        resetn      = 1'b0;
    logic        start       = 1'b0;
    logic        abort       = 1'b0;
    logic [7:0]  in_byte     = 8'd0;
    logic        in_valid    = 1'b0;
    logic        in_ready;
    logic [10:0] picture_wadrs;
    logic [23:0] picture_wdata;
    logic        picture_we;
    logic [3:0]  cur_row;
    logic [3:0]  cur_col;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_count;

    logic        start_s = 1'b0;
    logic        rdy_s;
    logic [10:0] wadrs_s;
    logic [23:0] wdata_s;
    logic        we_s;
    logic [3:0]  row_s;
    logic [3:0]  col_s;
    logic        busy_s;
    logic        done_s;
    logic [7:0]  fcnt_s;

    picture_writer dut (
        .picture_clk  (picture_clk),
        .resetn       (resetn),
        .start        (start),
        .abort        (abort),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .picture_wadrs(picture_wadrs),
        .picture_wdata(picture_wdata),
        .picture_we   (picture_we),
        .cur_row      (cur_row),
        .cur_col      (cur_col),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_count  (frame_count)
    );

    picture_writer #(
        .BASE_ADRS(100),
        .PIXELS   (4),
        .WIDTH    (2),
        .ADRS_W   (11)
    ) dut_small (
        .picture_clk  (picture_clk),
        .resetn       (resetn),
        .start        (start_s),
        .abort        (1'b0),
        .in_byte      (8'h5A),
        .in_valid     (1'b1),
        .in_ready     (rdy_s),
        .picture_wadrs(wadrs_s),
        .picture_wdata(wdata_s),
        .picture_we   (we_s),
        .cur_row      (row_s),
        .cur_col      (col_s),
        .busy         (busy_s),
        .frame_done   (done_s),
        .frame_count  (fcnt_s)
    );

    always #5 picture_clk = ~picture_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_we_cyc  = 0;
    int last_acc_cyc = 0;
    int rdy_viol  = 0;
    int fd_pulses = 0;
    int sw_cnt    = 0;
    logic [34:0] wlog[$];
    logic [23:0] exp_pix[256];

    always @(posedge picture_clk) cyc <= cyc + 1;

    always @(negedge picture_clk) begin
        if (resetn && picture_we) begin
            wlog.push_back({picture_wadrs, picture_wdata});
            last_we_cyc = cyc;
            if (in_ready) rdy_viol++;
        end
        if (resetn && frame_done) fd_pulses++;
        if (resetn && we_s) sw_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference: pixel k must land at 1792+k with exp_pix[k].
    function automatic int image_errors();
        int e = 0;
        for (int k = 0; k < wlog.size(); k++) begin
            if (wlog[k] !== {11'(1792 + k), exp_pix[k]}) e++;
        end
        return e;
    endfunction

    // Called and returning at a falling edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps,
                             inout bit ok);
        bit acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_byte  = b;
                acc      = in_ready;
                if (acc) last_acc_cyc = cyc;
            end
            @(posedge picture_clk);
            @(negedge picture_clk);
        end
        if (!acc) ok = 1'b0;
    endtask

    task automatic run_pixels(input int lo, input int hi, input bit gaps,
                              inout bit ok);
        for (int k = lo; k <= hi; k++) begin
            send_byte(exp_pix[k][23:16], gaps, ok);
            send_byte(exp_pix[k][15:8], gaps, ok);
            send_byte(exp_pix[k][7:0], gaps, ok);
            if (!ok) break;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge picture_clk);
        @(negedge picture_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int t = 0; t < 16; t++) begin
            if (frame_done) begin
                got = 1'b1;
                break;
            end
            @(negedge picture_clk);
        end
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'($urandom);
        repeat (3) @(negedge picture_clk);
        n_tests++;
        if ({in_ready, picture_we, busy, frame_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000",
                     {in_ready, picture_we, busy, frame_done});
        end
        n_tests++;
        if ({cur_row, cur_col, frame_count} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_counts: got %h required 0000",
                     {cur_row, cur_col, frame_count});
        end
        n_tests++;
        if (picture_wadrs !== 11'd1792 || picture_wdata !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_port: got %0d/%h required 1792/000000",
                     picture_wadrs, picture_wdata);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        resetn   = 1'b1;
        @(negedge picture_clk);
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy %b ready %b required 0 0",
                     busy, in_ready);
        end
    endtask

    task automatic test_single_pixel();
        bit ok = 1'b1;
        int c0;
        wlog.delete();
        exp_pix[0] = 24'h123456;
        pulse_start();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: in_ready %b required 1", in_ready);
        end
        send_byte(8'h12, 1'b0, ok);
        c0 = last_acc_cyc;
        send_byte(8'h34, 1'b0, ok);
        send_byte(8'h56, 1'b0, ok);
        in_valid = 1'b0;
        n_tests++;
        if (!ok || picture_we !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_we: ok %b we %b ready %b required 1 1 0",
                     ok, picture_we, in_ready);
        end
        n_tests++;
        if (picture_wadrs !== 11'd1792 || picture_wdata !== 24'h123456) begin
            n_fail++;
            $display("FAIL single_data: got %0d/%h required 1792/123456",
                     picture_wadrs, picture_wdata);
        end
        n_tests++;
        if (cyc !== c0 + 3) begin
            n_fail++;
            $display("FAIL single_latency: we at +%0d required +3",
                     cyc - c0);
        end
        @(negedge picture_clk);
        n_tests++;
        if (cur_col !== 4'd1 || cur_row !== 4'd0 || in_ready !== 1'b1
            || picture_we !== 1'b0 || picture_wdata !== 24'h123456) begin
            n_fail++;
            $display("FAIL single_next: col %0d row %0d rdy %b we %b d %h",
                     cur_col, cur_row, in_ready, picture_we, picture_wdata);
        end
        abort = 1'b1;
        @(posedge picture_clk);
        @(negedge picture_clk);
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || wlog.size() !== 1 || frame_count !== 8'd0) begin
            n_fail++;
            $display("FAIL single_abort: busy %b writes %0d fc %0d req 0 1 0",
                     busy, wlog.size(), frame_count);
        end
    endtask

    task automatic test_full_frame();
        bit ok = 1'b1;
        bit got;
        int s;
        int fd0 = fd_pulses;
        for (int k = 0; k < 256; k++) begin
            exp_pix[k] = {8'(k), ~8'(k), 8'hA5};
        end
        wlog.delete();
        pulse_start();
        s = cyc;
        run_pixels(0, 15, 1'b0, ok);
        in_valid = 1'b0;
        @(negedge picture_clk);
        n_tests++;
        if (cur_row !== 4'd1 || cur_col !== 4'd0) begin
            n_fail++;
            $display("FAIL full_rowcol: row %0d col %0d required 1 0",
                     cur_row, cur_col);
        end
        run_pixels(16, 255, 1'b0, ok);
        in_valid = 1'b0;
        wait_done(got);
        n_tests++;
        if (!ok || !got || cyc !== last_we_cyc + 1) begin
            n_fail++;
            $display("FAIL full_done: ok %b done %b gap %0d required 1 1 1",
                     ok, got, cyc - last_we_cyc);
        end
        n_tests++;
        if (last_we_cyc - s !== 1023 || frame_count !== 8'd1) begin
            n_fail++;
            $display("FAIL full_timing: span %0d fc %0d required 1023 1",
                     last_we_cyc - s, frame_count);
        end
        @(negedge picture_clk);
        n_tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || fd_pulses - fd0 !== 1) begin
            n_fail++;
            $display("FAIL full_end: busy %b fd %b pulses %0d required 0 0 1",
                     busy, frame_done, fd_pulses - fd0);
        end
        n_tests++;
        if (wlog.size() !== 256 || image_errors() !== 0) begin
            n_fail++;
            $display("FAIL full_image: writes %0d bad %0d required 256 0",
                     wlog.size(), image_errors());
        end
    endtask

    task automatic test_gaps();
        bit ok = 1'b1;
        bit got;
        wlog.delete();
        pulse_start();
        run_pixels(0, 255, 1'b1, ok);
        in_valid = 1'b0;
        wait_done(got);
        @(negedge picture_clk);
        n_tests++;
        if (!ok || !got || frame_count !== 8'd2) begin
            n_fail++;
            $display("FAIL gaps_done: ok %b done %b fc %0d required 1 1 2",
                     ok, got, frame_count);
        end
        n_tests++;
        if (wlog.size() !== 256 || image_errors() !== 0) begin
            n_fail++;
            $display("FAIL gaps_image: writes %0d bad %0d required 256 0",
                     wlog.size(), image_errors());
        end
        n_tests++;
        if (rdy_viol !== 0) begin
            n_fail++;
            $display("FAIL gaps_ready: %0d writes with in_ready, required 0",
                     rdy_viol);
        end
    endtask

    task automatic test_abort();
        bit ok = 1'b1;
        bit got;
        int fd0 = fd_pulses;
        for (int k = 0; k < 256; k++) exp_pix[k] = 24'($urandom);
        wlog.delete();
        pulse_start();
        run_pixels(0, 36, 1'b0, ok);
        send_byte(exp_pix[37][23:16], 1'b0, ok);
        send_byte(exp_pix[37][15:8], 1'b0, ok);
        in_valid = 1'b1;
        in_byte  = exp_pix[37][7:0];
        abort    = 1'b1;
        @(posedge picture_clk);
        @(negedge picture_clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy %b ready %b required 0 0",
                     busy, in_ready);
        end
        repeat (8) @(negedge picture_clk);
        n_tests++;
        if (!ok || wlog.size() !== 37 || fd_pulses !== fd0
            || frame_count !== 8'd2) begin
            n_fail++;
            $display("FAIL abort_effect: ok %b writes %0d fd %0d fc %0d",
                     ok, wlog.size(), fd_pulses - fd0, frame_count);
        end
        for (int k = 0; k < 256; k++) exp_pix[k] = 24'($urandom);
        wlog.delete();
        pulse_start();
        run_pixels(0, 255, 1'b1, ok);
        in_valid = 1'b0;
        wait_done(got);
        @(negedge picture_clk);
        n_tests++;
        if (wlog.size() == 0 || wlog[0] !== {11'd1792, exp_pix[0]}) begin
            n_fail++;
            $display("FAIL abort_restart: first write %h required %h",
                     wlog.size() ? wlog[0] : 35'h0, {11'd1792, exp_pix[0]});
        end
        n_tests++;
        if (!ok || !got || frame_count !== 8'd3 || wlog.size() !== 256
            || image_errors() !== 0) begin
            n_fail++;
            $display("FAIL abort_frame: done %b fc %0d writes %0d bad %0d",
                     got, frame_count, wlog.size(), image_errors());
        end
    endtask

    task automatic test_wrap();
        int wrap_err = 0;
        int ign_err  = 0;
        bit got      = 1'b1;
        for (int f = 0; f < 256; f++) begin
            // start stays high across the whole frame and the DONE cycle
            start_s = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 60; t++) begin
                @(negedge picture_clk);
                if (done_s) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) break;
            if (fcnt_s !== 8'((f + 1) % 256)) wrap_err++;
            @(negedge picture_clk);
            if (busy_s) ign_err++;
            start_s = 1'b0;
            @(negedge picture_clk);
        end
        start_s = 1'b0;
        n_tests++;
        if (!got || fcnt_s !== 8'd0 || wrap_err !== 0) begin
            n_fail++;
            $display("FAIL wrap_count: done %b fc %0d bad %0d required 1 0 0",
                     got, fcnt_s, wrap_err);
        end
        n_tests++;
        if (ign_err !== 0 || sw_cnt !== 1024) begin
            n_fail++;
            $display("FAIL wrap_start: restarts %0d writes %0d req 0 1024",
                     ign_err, sw_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_full_frame();
        test_gaps();
        test_abort();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
